// File: rtl/m_frame_scheduler_pkg.sv
// m_frame_scheduler_pkg: frame sequencer state encoding and framebuffer field widths
package m_frame_scheduler_pkg;
  localparam int FB_XW = 8;
  localparam int FB_YW = 7;
  localparam int FB_CW = 3;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_LOGIC,
    S_COLLIDE,
    S_RENDER,
    S_GAME_OVER
  } state_t;
endpackage

// File: rtl/m_fb_write_arbiter.sv
// m_fb_write_arbiter: fixed-priority (bg over rd) framebuffer write mux with a registered port
module m_fb_write_arbiter
  import m_frame_scheduler_pkg::*;
(
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [FB_XW-1:0] bg_x_i,
  input  logic [FB_YW-1:0] bg_y_i,
  input  logic [FB_CW-1:0] bg_color_i,
  input  logic             bg_wren_i,
  input  logic [FB_XW-1:0] rd_x_i,
  input  logic [FB_YW-1:0] rd_y_i,
  input  logic [FB_CW-1:0] rd_color_i,
  input  logic             rd_wren_i,
  output logic             rd_grant_o,
  output logic [FB_XW-1:0] fb_x_o,
  output logic [FB_YW-1:0] fb_y_o,
  output logic [FB_CW-1:0] fb_color_o,
  output logic             fb_wren_o
);
  logic [FB_XW-1:0] x_q, x_d;
  logic [FB_YW-1:0] y_q, y_d;
  logic [FB_CW-1:0] c_q, c_d;
  logic             wren_q, wren_d;
  // select the winner; coordinates and color hold while nobody writes
  always_comb begin
    rd_grant_o = rd_wren_i && !bg_wren_i;
    wren_d     = bg_wren_i || rd_grant_o;
    x_d        = bg_wren_i ? bg_x_i : rd_grant_o ? rd_x_i : x_q;
    y_d        = bg_wren_i ? bg_y_i : rd_grant_o ? rd_y_i : y_q;
    c_d        = bg_wren_i ? bg_color_i : rd_grant_o ? rd_color_i : c_q;
  end
  // one-cycle output register toward the framebuffer
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      x_q    <= '0;
      y_q    <= '0;
      c_q    <= '0;
      wren_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      c_q    <= c_d;
      wren_q <= wren_d;
    end
  end
  assign fb_x_o     = x_q;
  assign fb_y_o     = y_q;
  assign fb_color_o = c_q;
  assign fb_wren_o  = wren_q;
endmodule

// File: rtl/m_frame_scheduler.sv
// m_frame_scheduler: per-tick game sequencer (logic, collide, render) with framebuffer arbitration; optional logic watchdog via M_FRAME_SCHED_WDOG_EN
module m_frame_scheduler
  import m_frame_scheduler_pkg::*;
#(
  parameter int TICK_DIV    = 2500000,
  parameter int LIVES       = 3,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             logic_enable,
  input  logic             logic_finished,
  output logic             collide_enable,
  input  logic             ghost_collision,
  output logic             render_start,
  input  logic             render_done,
  input  logic [FB_XW-1:0] bg_x,
  input  logic [FB_YW-1:0] bg_y,
  input  logic [FB_CW-1:0] bg_color,
  input  logic             bg_wren,
  input  logic [FB_XW-1:0] rd_x,
  input  logic [FB_YW-1:0] rd_y,
  input  logic [FB_CW-1:0] rd_color,
  input  logic             rd_wren,
  output logic             rd_grant,
  output logic [FB_XW-1:0] fb_x,
  output logic [FB_YW-1:0] fb_y,
  output logic [FB_CW-1:0] fb_color,
  output logic             fb_wren,
  output logic [2:0]       lives,
  output logic             game_over,
  output logic [15:0]      frame_count,
  output logic             tick_overrun,
  output logic             wdog_err
);
  localparam int TW = $clog2(TICK_DIV);
  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    lives_q, lives_d;
  logic [15:0]   frames_q, frames_d;
  logic          pend_q, pend_d, ovr_q, ovr_d, wdog_q, wdog_d, rs_q, rs_d;
  logic          run, wrap, busy, go, fired;
`ifdef M_FRAME_SCHED_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wd_q;
  // cycles spent in LOGIC, restarted whenever LOGIC is left
  always_ff @(posedge clock) begin
    if (reset || state_q != S_LOGIC) wd_q <= '0;
    else wd_q <= wd_q + 1'b1;
  end
  assign fired = state_q == S_LOGIC && !logic_finished && wd_q == WW'(WDOG_CYCLES - 1);
`else
  logic unused_wdog;
  assign unused_wdog = WDOG_CYCLES != 0;
  assign fired = 1'b0;
`endif
  // tick divider, single-entry tick queue, sticky flags and frame FSM next state
  always_comb begin
    run      = state_q != S_IDLE && state_q != S_GAME_OVER;
    wrap     = run && tick_q == TW'(TICK_DIV - 1);
    busy     = state_q == S_LOGIC || state_q == S_COLLIDE || state_q == S_RENDER;
    go       = start && !run;
    state_d  = state_q;
    tick_d   = (wrap || !run) ? '0 : tick_q + 1'b1;
    pend_d   = run && (wrap || (pend_q && state_q != S_WAIT_TICK));
    ovr_d    = !go && (ovr_q || (wrap && (pend_q || busy)));
    wdog_d   = !go && (wdog_q || fired);
    lives_d  = go ? 3'(LIVES) : lives_q;
    frames_d = go ? '0 : frames_q;
    case (state_q)
      S_IDLE, S_GAME_OVER: state_d = start ? S_WAIT_TICK : state_q;
      S_WAIT_TICK: state_d = pend_q ? S_LOGIC : S_WAIT_TICK;
      S_LOGIC: state_d = logic_finished ? S_COLLIDE : fired ? S_RENDER : S_LOGIC;
      S_COLLIDE: begin
        lives_d = ghost_collision ? lives_q - 3'd1 : lives_q;
        state_d = (ghost_collision && lives_q == 3'd1) ? S_GAME_OVER : S_RENDER;
      end
      S_RENDER: begin
        state_d  = render_done ? S_WAIT_TICK : S_RENDER;
        frames_d = render_done ? frames_q + 16'd1 : frames_q;
      end
      default: state_d = S_IDLE;
    endcase
    rs_d = state_d == S_RENDER && state_q != S_RENDER;
  end
  // state and counters; reset aborts any frame in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      lives_q  <= 3'(LIVES);
      frames_q <= '0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      wdog_q   <= 1'b0;
      rs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      lives_q  <= lives_d;
      frames_q <= frames_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      wdog_q   <= wdog_d;
      rs_q     <= rs_d;
    end
  end
  assign logic_enable   = state_q == S_LOGIC;
  assign collide_enable = state_q == S_COLLIDE;
  assign render_start   = rs_q;
  assign game_over      = state_q == S_GAME_OVER;
  assign lives          = lives_q;
  assign frame_count    = frames_q;
  assign tick_overrun   = ovr_q;
  assign wdog_err       = wdog_q;
  m_fb_write_arbiter u_arb (
    .clock_i    (clock),
    .reset_i    (reset),
    .bg_x_i     (bg_x),
    .bg_y_i     (bg_y),
    .bg_color_i (bg_color),
    .bg_wren_i  (bg_wren),
    .rd_x_i     (rd_x),
    .rd_y_i     (rd_y),
    .rd_color_i (rd_color),
    .rd_wren_i  (rd_wren),
    .rd_grant_o (rd_grant),
    .fb_x_o     (fb_x),
    .fb_y_o     (fb_y),
    .fb_color_o (fb_color),
    .fb_wren_o  (fb_wren)
  );
endmodule

// File: tb/tb_m_frame_scheduler.sv
// tb_m_frame_scheduler: directed scenario bench for the frame scheduler
module tb_m_frame_scheduler;
  localparam int TICK_DIV = 16;
  localparam int LIVES = 3;
  localparam int WDOG = 32;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic logic_finished = 1'b0, ghost_collision = 1'b0, render_done = 1'b0;
  logic [7:0] bg_x = '0, rd_x = '0;
  logic [6:0] bg_y = '0, rd_y = '0;
  logic [2:0] bg_color = '0, rd_color = '0;
  logic bg_wren = 1'b0, rd_wren = 1'b0;
  logic logic_enable, collide_enable, render_start, rd_grant, fb_wren, game_over, tick_overrun, wdog_err;
  logic [7:0] fb_x;
  logic [6:0] fb_y;
  logic [2:0] fb_color, lives;
  logic [15:0] frame_count;
  int n_vec = 0, n_err = 0;
  int n_le = 0, n_ce = 0, n_rs = 0;

  m_frame_scheduler #(.TICK_DIV(TICK_DIV), .LIVES(LIVES), .WDOG_CYCLES(WDOG)) dut (
    .clock(clock), .reset(reset), .start(start),
    .logic_enable(logic_enable), .logic_finished(logic_finished),
    .collide_enable(collide_enable), .ghost_collision(ghost_collision),
    .render_start(render_start), .render_done(render_done),
    .bg_x(bg_x), .bg_y(bg_y), .bg_color(bg_color), .bg_wren(bg_wren),
    .rd_x(rd_x), .rd_y(rd_y), .rd_color(rd_color), .rd_wren(rd_wren),
    .rd_grant(rd_grant), .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_wren(fb_wren),
    .lives(lives), .game_over(game_over), .frame_count(frame_count),
    .tick_overrun(tick_overrun), .wdog_err(wdog_err)
  );

  always #5 clock = ~clock;

  // cycle counts of the sequencing strobes, sampled mid-cycle
  always @(negedge clock) begin
    if (logic_enable) n_le++;
    if (collide_enable) n_ce++;
    if (render_start) n_rs++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_logic(input string tag);
    int n = 0;
    while (logic_enable !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    n_vec++;
    if (logic_enable !== 1'b1) begin
      n_err++;
      $display("FAIL %s_logic_timeout: logic_enable=%b want 1", tag, logic_enable);
    end
  endtask

  // entered in the first LOGIC cycle; returns in the cycle after COLLIDE
  task automatic run_logic(input int lf, input logic gc);
    step(lf - 1);
    logic_finished = 1'b1;
    step();
    logic_finished = 1'b0;
    ghost_collision = gc;
    step();
    ghost_collision = 1'b0;
  endtask

  // entered in the first RENDER cycle; done is raised in RENDER cycle rdel
  task automatic finish_render(input int rdel);
    step(rdel - 1);
    render_done = 1'b1;
    step();
    render_done = 1'b0;
  endtask

  task automatic test_reset;
    step(3);
    n_vec++; if (lives !== 3'd3) begin n_err++; $display("FAIL reset_lives: got %0d want 3", lives); end
    n_vec++; if ({logic_enable, collide_enable, render_start, game_over, tick_overrun, wdog_err, fb_wren} !== 7'b0) begin
      n_err++; $display("FAIL reset_flags: got %b want 0000000", {logic_enable, collide_enable, render_start, game_over, tick_overrun, wdog_err, fb_wren});
    end
    n_vec++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL reset_frames: got %0d want 0", frame_count); end
    reset = 1'b0;
    render_done = 1'b1;
    step(2);
    render_done = 1'b0;
    step(20);
    n_vec++; if (logic_enable !== 1'b0 || frame_count !== 16'd0) begin
      n_err++; $display("FAIL idle_hold: logic_enable=%b frames=%0d want 0 0", logic_enable, frame_count);
    end
  endtask

  task automatic test_contention;
    bg_x = 8'h12; bg_y = 7'h34; bg_color = 3'd5; bg_wren = 1'b1;
    rd_x = 8'hAB; rd_y = 7'h55; rd_color = 3'd2; rd_wren = 1'b1;
    #1;
    n_vec++; if (rd_grant !== 1'b0) begin n_err++; $display("FAIL grant_c1: got %b want 0", rd_grant); end
    step();
    n_vec++; if ({fb_wren, fb_x, fb_y, fb_color} !== {1'b1, 8'h12, 7'h34, 3'd5}) begin
      n_err++; $display("FAIL fb_bg1: got %b %h %h %0d want 1 12 34 5", fb_wren, fb_x, fb_y, fb_color);
    end
    bg_x = 8'h13;
    #1;
    n_vec++; if (rd_grant !== 1'b0) begin n_err++; $display("FAIL grant_c2: got %b want 0", rd_grant); end
    step();
    n_vec++; if ({fb_wren, fb_x, fb_y, fb_color} !== {1'b1, 8'h13, 7'h34, 3'd5}) begin
      n_err++; $display("FAIL fb_bg2: got %b %h %h %0d want 1 13 34 5", fb_wren, fb_x, fb_y, fb_color);
    end
    bg_wren = 1'b0;
    #1;
    n_vec++; if (rd_grant !== 1'b1) begin n_err++; $display("FAIL grant_c3: got %b want 1", rd_grant); end
    step();
    n_vec++; if ({fb_wren, fb_x, fb_y, fb_color} !== {1'b1, 8'hAB, 7'h55, 3'd2}) begin
      n_err++; $display("FAIL fb_rd: got %b %h %h %0d want 1 ab 55 2", fb_wren, fb_x, fb_y, fb_color);
    end
    rd_wren = 1'b0;
    rd_x = 8'h00;
    step();
    n_vec++; if ({fb_wren, fb_x, fb_y, fb_color} !== {1'b0, 8'hAB, 7'h55, 3'd2}) begin
      n_err++; $display("FAIL fb_hold: got %b %h %h %0d want 0 ab 55 2", fb_wren, fb_x, fb_y, fb_color);
    end
  endtask

  task automatic test_full_frame;
    int a, b, c;
    start = 1'b1;
    step();
    start = 1'b0;
    a = n_le; b = n_ce; c = n_rs;
    wait_logic("full");
    run_logic(5, 1'b0);
    n_vec++; if (render_start !== 1'b1) begin n_err++; $display("FAIL full_render_start: got %b want 1", render_start); end
    finish_render(8);
    n_vec++; if (n_le - a != 5) begin n_err++; $display("FAIL full_logic_cycles: got %0d want 5", n_le - a); end
    n_vec++; if (n_ce - b != 1) begin n_err++; $display("FAIL full_collide_cycles: got %0d want 1", n_ce - b); end
    n_vec++; if (n_rs - c != 1) begin n_err++; $display("FAIL full_render_pulses: got %0d want 1", n_rs - c); end
    n_vec++; if (frame_count !== 16'd1) begin n_err++; $display("FAIL full_frames: got %0d want 1", frame_count); end
    n_vec++; if (tick_overrun !== 1'b0 || lives !== 3'd3) begin
      n_err++; $display("FAIL full_flags: overrun=%b lives=%0d want 0 3", tick_overrun, lives);
    end
  endtask

  task automatic test_game_over;
    int a, b;
    wait_logic("go1");
    run_logic(2, 1'b1);
    n_vec++; if (lives !== 3'd2 || render_start !== 1'b1) begin
      n_err++; $display("FAIL hit1: lives=%0d render_start=%b want 2 1", lives, render_start);
    end
    finish_render(3);
    wait_logic("go2");
    run_logic(2, 1'b1);
    n_vec++; if (lives !== 3'd1 || render_start !== 1'b1) begin
      n_err++; $display("FAIL hit2: lives=%0d render_start=%b want 1 1", lives, render_start);
    end
    finish_render(3);
    wait_logic("go3");
    run_logic(2, 1'b1);
    n_vec++; if (lives !== 3'd0 || game_over !== 1'b1 || render_start !== 1'b0) begin
      n_err++; $display("FAIL hit3: lives=%0d game_over=%b render_start=%b want 0 1 0", lives, game_over, render_start);
    end
    n_vec++; if (frame_count !== 16'd3) begin n_err++; $display("FAIL go_frames: got %0d want 3", frame_count); end
    a = n_rs; b = n_le;
    render_done = 1'b1;
    step(40);
    render_done = 1'b0;
    n_vec++; if (n_rs != a || n_le != b || game_over !== 1'b1 || frame_count !== 16'd3) begin
      n_err++; $display("FAIL go_idle: render_starts=%0d logic_cycles=%0d game_over=%b frames=%0d want 0 0 1 3", n_rs - a, n_le - b, game_over, frame_count);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_vec++; if (lives !== 3'd3 || frame_count !== 16'd0 || game_over !== 1'b0 || tick_overrun !== 1'b0) begin
      n_err++; $display("FAIL restart: lives=%0d frames=%0d game_over=%b overrun=%b want 3 0 0 0", lives, frame_count, game_over, tick_overrun);
    end
  endtask

  task automatic test_overrun;
    wait_logic("ovr");
    run_logic(1, 1'b0);
    finish_render(40);
    n_vec++; if (tick_overrun !== 1'b1 || logic_enable !== 1'b0) begin
      n_err++; $display("FAIL ovr_flag: overrun=%b logic_enable=%b want 1 0", tick_overrun, logic_enable);
    end
    step();
    n_vec++; if (logic_enable !== 1'b1) begin n_err++; $display("FAIL ovr_immediate: logic_enable=%b want 1", logic_enable); end
    run_logic(1, 1'b0);
    finish_render(1);
    n_vec++; if (logic_enable !== 1'b0) begin n_err++; $display("FAIL ovr_once_a: logic_enable=%b want 0", logic_enable); end
    step();
    n_vec++; if (logic_enable !== 1'b0) begin n_err++; $display("FAIL ovr_once_b: logic_enable=%b want 0", logic_enable); end
    step();
    n_vec++; if (logic_enable !== 1'b1) begin n_err++; $display("FAIL ovr_next_tick: logic_enable=%b want 1", logic_enable); end
    n_vec++; if (frame_count !== 16'd2) begin n_err++; $display("FAIL ovr_frames: got %0d want 2", frame_count); end
  endtask

  task automatic test_mid_reset;
    int a;
    run_logic(1, 1'b0);
    step(2);
    reset = 1'b1;
    step();
    n_vec++; if ({logic_enable, collide_enable, render_start, game_over, tick_overrun, wdog_err, fb_wren} !== 7'b0) begin
      n_err++; $display("FAIL mrst_flags: got %b want 0000000", {logic_enable, collide_enable, render_start, game_over, tick_overrun, wdog_err, fb_wren});
    end
    n_vec++; if ({fb_x, fb_y, fb_color} !== 18'b0 || frame_count !== 16'd0 || lives !== 3'd3) begin
      n_err++; $display("FAIL mrst_regs: fb=%h/%h/%0d frames=%0d lives=%0d want 0/0/0 0 3", fb_x, fb_y, fb_color, frame_count, lives);
    end
    reset = 1'b0;
    render_done = 1'b1;
    step();
    render_done = 1'b0;
    a = n_le;
    step(40);
    n_vec++; if (frame_count !== 16'd0 || n_le != a || render_start !== 1'b0) begin
      n_err++; $display("FAIL mrst_idle: frames=%0d logic_cycles=%0d render_start=%b want 0 0 0", frame_count, n_le - a, render_start);
    end
  endtask

  task automatic test_watchdog;
    int a;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_logic("wdog");
    a = n_le;
`ifdef M_FRAME_SCHED_WDOG_EN
    step(WDOG);
    n_vec++; if (logic_enable !== 1'b0 || n_le - a != WDOG) begin
      n_err++; $display("FAIL wdog_drop: logic_enable=%b logic_cycles=%0d want 0 %0d", logic_enable, n_le - a, WDOG);
    end
    n_vec++; if (wdog_err !== 1'b1 || render_start !== 1'b1) begin
      n_err++; $display("FAIL wdog_render: wdog_err=%b render_start=%b want 1 1", wdog_err, render_start);
    end
    finish_render(2);
`else
    step(WDOG + 8);
    n_vec++; if (logic_enable !== 1'b1 || wdog_err !== 1'b0 || n_le - a != WDOG + 8) begin
      n_err++; $display("FAIL wdog_off_wait: logic_enable=%b wdog_err=%b logic_cycles=%0d want 1 0 %0d", logic_enable, wdog_err, n_le - a, WDOG + 8);
    end
    run_logic(1, 1'b0);
    n_vec++; if (render_start !== 1'b1 || wdog_err !== 1'b0) begin
      n_err++; $display("FAIL wdog_off_render: render_start=%b wdog_err=%b want 1 0", render_start, wdog_err);
    end
    finish_render(1);
`endif
    n_vec++; if (frame_count !== 16'd1) begin n_err++; $display("FAIL wdog_frames: got %0d want 1", frame_count); end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_full_frame();
    test_game_over();
    test_overrun();
    test_mid_reset();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
